operand_issue_stage: RTL

- Decode/issue stage directly upstream of the execution unit.
- Accepts 16-bit instructions and reads two source operands from an internal 8-entry register file.
- Presents a registered {operanda, operandb, alu_op, rd} bundle to the execution unit through a valid/ready handshake.
- Accepts the writeback of completed results from downstream. A per-register pending scoreboard blocks RAW and WAW hazards.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/regfile_2r1w.sv | 38 +++
 rtl/operand_issue_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the operand issue stage and its register file.
//   - datapath width, register file depth and register index width
//   - instruction field bit positions for the 16-bit instruction word
//   - ALU operation codes (codes above ALU_SUB are reserved)
//   - output slot state encoding
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int NREG    = 8;
    localparam int REG_W   = $clog2(NREG);
    localparam int IMM_W   = 6;
    localparam int INSTR_W = 16;
    localparam int OP_W    = 3;

    // Instruction field positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RD_MSB   = 12;
    localparam int RD_LSB   = 10;
    localparam int RSA_MSB  = 9;
    localparam int RSA_LSB  = 7;
    localparam int USE_IMM  = 6;
    localparam int RSB_MSB  = 5;
    localparam int RSB_LSB  = 3;
    localparam int IMM_MSB  = 5;
    localparam int IMM_LSB  = 0;

    localparam logic [OP_W-1:0] ALU_PASS = 3'b000;
    localparam logic [OP_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b010;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Entry 0 is hardwired to zero (reads return 0, writes are dropped).
// Synchronous active-high reset clears every entry.
//   clk, rst              clock / synchronous reset
//   ra_a_i, ra_b_i        read addresses
//   rd_a_o, rd_b_o        read data (combinational)
//   we_i, wa_i, wd_i      write enable / address / data
module regfile_2r1w #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] ra_a_i,
    input  logic [$clog2(NREG)-1:0] ra_b_i,
    output logic [DATA_W-1:0]       rd_a_o,
    output logic [DATA_W-1:0]       rd_b_o,
    input  logic                    we_i,
    input  logic [$clog2(NREG)-1:0] wa_i,
    input  logic [DATA_W-1:0]       wd_i
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (ra_a_i == '0) ? '0 : mem_q[ra_a_i];
    assign rd_b_o = (ra_b_i == '0) ? '0 : mem_q[ra_b_i];

endmodule

// File: rtl/operand_issue_stage.sv
// Decode / operand issue stage feeding the execution unit.
// Decodes a 16-bit instruction, reads two sources from the register file
// (with same-cycle writeback bypass), blocks RAW/WAW hazards with a
// per-register pending scoreboard and holds the issue bundle in a one-entry
// output slot with a valid/ready handshake.
//   clk, rst                    clock / synchronous active-high reset
//   instr, instr_valid/ready    instruction input handshake
//   issue_valid/ready           issue bundle handshake
//   operanda, operandb          source A, source B or zero-extended immediate
//   alu_op, rd                  pass-through opcode and destination index
//   wb_en, wb_addr, wb_data     writeback from downstream
module operand_issue_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = cpu_pkg::NREG,
    parameter int IMM_W  = cpu_pkg::IMM_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             instr,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [DATA_W-1:0]       operanda,
    output logic [DATA_W-1:0]       operandb,
    output logic [2:0]              alu_op,
    output logic [$clog2(NREG)-1:0] rd,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DATA_W-1:0]       wb_data
);

    import cpu_pkg::*;

    localparam int RW = $clog2(NREG);

    // Decoded fields
    logic [2:0]       f_op;
    logic [RW-1:0]    f_rd;
    logic [RW-1:0]    f_rsa;
    logic [RW-1:0]    f_rsb;
    logic             f_use_imm;
    logic [IMM_W-1:0] f_imm;

    assign f_op      = instr[OP_MSB:OP_LSB];
    assign f_rd      = instr[RD_MSB:RD_LSB];
    assign f_rsa     = instr[RSA_MSB:RSA_LSB];
    assign f_rsb     = instr[RSB_MSB:RSB_LSB];
    assign f_use_imm = instr[USE_IMM];
    assign f_imm     = instr[IMM_W-1:0];

    // Register file
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .ra_a_i (f_rsa),
        .ra_b_i (f_rsb),
        .rd_a_o (rf_a),
        .rd_b_o (rf_b),
        .we_i   (wb_en),
        .wa_i   (wb_addr),
        .wd_i   (wb_data)
    );

    // Scoreboard
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] acc_set;
    logic [NREG-1:0] pend_eff;
    logic            hazard;
    logic            accept;

    always_comb begin
        wb_clr  = '0;
        acc_set = '0;
        if (wb_en) begin
            wb_clr[wb_addr] = 1'b1;
        end
        if (accept && (f_rd != '0)) begin
            acc_set[f_rd] = 1'b1;
        end
    end

    // A register being written back this cycle no longer blocks issue.
    assign pend_eff = pending_q & ~wb_clr;

    assign hazard = pend_eff[f_rsa]
                  | (~f_use_imm & pend_eff[f_rsb])
                  | pend_eff[f_rd];

    assign instr_ready = ~rst & ~hazard & (~issue_valid | issue_ready);
    assign accept      = instr_valid & instr_ready;

    // Set after clear: a new producer of rd wins over a same-cycle writeback.
    assign pending_d = pend_eff | acc_set;

    // Operand selection with writeback bypass (R0 never bypassed)
    logic              wb_hit_a;
    logic              wb_hit_b;
    logic [DATA_W-1:0] opa_d;
    logic [DATA_W-1:0] opb_d;

    assign wb_hit_a = wb_en && (wb_addr != '0) && (wb_addr == f_rsa);
    assign wb_hit_b = wb_en && (wb_addr != '0) && (wb_addr == f_rsb);

    assign opa_d = wb_hit_a ? wb_data : rf_a;
    assign opb_d = f_use_imm ? {{(DATA_W-IMM_W){1'b0}}, f_imm}
                             : (wb_hit_b ? wb_data : rf_b);

    // Output slot
    slot_state_e slot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= SLOT_EMPTY;
            operanda  <= '0;
            operandb  <= '0;
            alu_op    <= '0;
            rd        <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            case (slot_q)
                SLOT_EMPTY: begin
                    if (accept) begin
                        slot_q   <= SLOT_FULL;
                        operanda <= opa_d;
                        operandb <= opb_d;
                        alu_op   <= f_op;
                        rd       <= f_rd;
                    end
                end
                SLOT_FULL: begin
                    // accept implies the held bundle leaves this cycle too
                    if (accept) begin
                        operanda <= opa_d;
                        operandb <= opb_d;
                        alu_op   <= f_op;
                        rd       <= f_rd;
                    end else if (issue_ready) begin
                        slot_q <= SLOT_EMPTY;
                    end
                end
                default: slot_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign issue_valid = (slot_q == SLOT_FULL);

endmodule
